// File: rtl/mult_booth4_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_booth4_unit
// Description : Radix-4 Booth iterative integer multiplier for the execute
//               stage. Handles MUL / MULH / MULHSU / MULHU, retires two
//               multiplier bits per cycle, early-outs on zero operands, and
//               hands a tagged result to the CDB under a valid/yumi handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_booth4_unit #(
    parameter int WIDTH      = 32,
    parameter int ROB_W      = 4,
    parameter int EARLY_ZERO = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       ALUop,
    input  logic [ROB_W-1:0] rs_rob_entry,
    input  logic             flush,
    input  logic             yumi_in,
    output logic             ready,
    output logic             valid_out,
    output logic [ROB_W-1:0] out_rob,
    output logic [WIDTH-1:0] out_result,
    output logic             out_branch_result,
    output logic             out_load_step1
);

    // Operands are widened by two bits so that unsigned 32-bit values become
    // non-negative signed numbers; the Booth recoder then sees a signed
    // multiplier of even width and needs exactly EXT_W/2 steps.
    localparam int c_EXT_W = WIDTH + 2;
    // Two further guard bits keep acc +/- 2*multiplicand from overflowing.
    localparam int c_ACC_W = WIDTH + 4;
    localparam int c_ITER  = WIDTH / 2 + 1;
    localparam int c_CNT_W = $clog2(c_ITER + 1);

    localparam logic [c_CNT_W-1:0] c_ITER_CNT = c_CNT_W'(c_ITER);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(1);

    localparam logic [1:0] c_MODE_MUL   = 2'b00;
    localparam logic [1:0] c_MODE_MULHU = 2'b11;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_BUSY = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;

    logic [ROB_W-1:0]   r_rob;
    logic [1:0]         r_mode;
    logic [c_EXT_W-1:0] r_mcand;
    logic [c_EXT_W-1:0] r_mplr;
    logic               r_bm1;
    logic [c_ACC_W-1:0] r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;

    logic               w_a_signed;
    logic               w_b_signed;
    logic [c_EXT_W-1:0] w_a_ext;
    logic [c_EXT_W-1:0] w_b_ext;
    logic               w_early;
    logic               w_accept;
    logic               w_step;
    logic               w_last;

    logic [2:0]         w_triplet;
    logic [c_ACC_W-1:0] w_mcand_sx;
    logic [c_ACC_W-1:0] w_mcand_x2;
    logic [c_ACC_W-1:0] w_pp;
    logic [c_ACC_W-1:0] w_acc_sum;
    logic [c_ACC_W-1:0] w_acc_sh;
    logic [c_EXT_W-1:0] w_mplr_sh;
    logic [WIDTH-1:0]   w_final_result;

    // ------------------------------------------------------------------
    // Operand extension and issue qualification
    // ------------------------------------------------------------------
    // rs1 is signed for MUL/MULH/MULHSU, rs2 only for MUL/MULH.
    assign w_a_signed = (ALUop != c_MODE_MULHU);
    assign w_b_signed = ~ALUop[1];
    assign w_a_ext    = {{2{w_a_signed & A[WIDTH-1]}}, A};
    assign w_b_ext    = {{2{w_b_signed & B[WIDTH-1]}}, B};

    assign w_early  = (EARLY_ZERO != 0) && ((A == '0) || (B == '0));
    // Flush wins over a simultaneous issue.
    assign w_accept = valid_in && (r_state == c_S_IDLE) && !flush;
    assign w_step   = (r_state == c_S_BUSY) && !flush;
    assign w_last   = (r_cnt == c_LAST_CNT);

    // ------------------------------------------------------------------
    // Booth step datapath
    // ------------------------------------------------------------------
    assign w_triplet  = {r_mplr[1:0], r_bm1};
    assign w_mcand_sx = {{2{r_mcand[c_EXT_W-1]}}, r_mcand};
    assign w_mcand_x2 = {w_mcand_sx[c_ACC_W-2:0], 1'b0};

    // Recode the current triplet into a partial product of 0, +/-A, +/-2A.
    always_comb begin
        w_pp = '0;
        case (w_triplet)
            3'b001, 3'b010: w_pp = w_mcand_sx;
            3'b011:         w_pp = w_mcand_x2;
            3'b100:         w_pp = -w_mcand_x2;
            3'b101, 3'b110: w_pp = -w_mcand_sx;
            default:        w_pp = '0;
        endcase
    end

    assign w_acc_sum = r_acc + w_pp;
    // Arithmetic shift of {acc, multiplier} right by two.
    assign w_acc_sh  = {{2{w_acc_sum[c_ACC_W-1]}}, w_acc_sum[c_ACC_W-1:2]};
    assign w_mplr_sh = {w_acc_sum[1:0], r_mplr[c_EXT_W-1:2]};

    // After the final step the product's low WIDTH+2 bits sit in the
    // multiplier register and the rest in the accumulator.
    assign w_final_result = (r_mode == c_MODE_MUL)
                          ? w_mplr_sh[WIDTH-1:0]
                          : {w_acc_sh[WIDTH-3:0], w_mplr_sh[c_EXT_W-1:WIDTH]};

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_early ? c_S_DONE : c_S_BUSY;
                end
            end
            c_S_BUSY: begin
                if (w_last) begin
                    w_state_next = c_S_DONE;
                end
            end
            c_S_DONE: begin
                if (yumi_in) begin
                    w_state_next = c_S_IDLE;
                end
            end
            default: w_state_next = c_S_IDLE;
        endcase
        if (flush) begin
            w_state_next = c_S_IDLE;
        end
    end

    // Operand capture on issue, one Booth step per busy cycle, result
    // capture on the last step. Nothing here moves while in S_DONE, which
    // keeps the presented result and tag stable under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rob    <= '0;
            r_mode   <= '0;
            r_mcand  <= '0;
            r_mplr   <= '0;
            r_bm1    <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_rob   <= rs_rob_entry;
            r_mode  <= ALUop;
            r_mcand <= w_a_ext;
            r_mplr  <= w_b_ext;
            r_bm1   <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= c_ITER_CNT;
            if (w_early) begin
                r_result <= '0;
            end
        end else if (w_step) begin
            r_acc  <= w_acc_sh;
            r_mplr <= w_mplr_sh;
            r_bm1  <= r_mplr[1];
            r_cnt  <= r_cnt - c_LAST_CNT;
            if (w_last) begin
                r_result <= w_final_result;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: state-decoded or registered only
    // ------------------------------------------------------------------
    assign ready             = (r_state == c_S_IDLE);
    assign valid_out         = (r_state == c_S_DONE);
    assign out_rob           = r_rob;
    assign out_result        = r_result;
    assign out_branch_result = 1'b0;
    assign out_load_step1    = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_mult_booth4_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_booth4_unit
// Description : Self-checking bench for mult_booth4_unit: directed vector
//               table, backpressure/flush/reset sequences, EARLY_ZERO=0
//               latency, and reference-model sweeps at WIDTH 32 and 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_booth4_unit;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [3:0]  tag;
        logic [31:0] exp;
        int          cyc;
    } vec_t;

    localparam int c_NV = 16;

    logic        clk = 1'b0;
    logic        reset, flush;
    // main instance: WIDTH=32, EARLY_ZERO=1
    logic        valid_in, yumi, ready, valid_out, out_br, out_ld;
    logic [31:0] a, b, out_result;
    logic [1:0]  aluop;
    logic [3:0]  tag, out_rob;
    // WIDTH=32, EARLY_ZERO=0
    logic        nz_valid, nz_yumi, nz_ready, nz_valid_out, nz_br, nz_ld;
    logic [31:0] nz_a, nz_b, nz_result;
    logic [1:0]  nz_op;
    logic [3:0]  nz_tag, nz_rob;
    // WIDTH=8, EARLY_ZERO=0
    logic        s8_valid, s8_yumi, s8_ready, s8_valid_out, s8_br, s8_ld;
    logic [7:0]  s8_a, s8_b, s8_result;
    logic [1:0]  s8_op;
    logic [3:0]  s8_tag, s8_rob;

    int checks = 0;
    int errors = 0;
    vec_t vecs[c_NV];

    always #5 clk = ~clk;

    mult_booth4_unit #(.WIDTH(32), .ROB_W(4), .EARLY_ZERO(1)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .A(a), .B(b), .ALUop(aluop),
        .rs_rob_entry(tag), .flush(flush), .yumi_in(yumi), .ready(ready),
        .valid_out(valid_out), .out_rob(out_rob), .out_result(out_result),
        .out_branch_result(out_br), .out_load_step1(out_ld));

    mult_booth4_unit #(.WIDTH(32), .ROB_W(4), .EARLY_ZERO(0)) dut_nz (
        .clk(clk), .reset(reset), .valid_in(nz_valid), .A(nz_a), .B(nz_b), .ALUop(nz_op),
        .rs_rob_entry(nz_tag), .flush(flush), .yumi_in(nz_yumi), .ready(nz_ready),
        .valid_out(nz_valid_out), .out_rob(nz_rob), .out_result(nz_result),
        .out_branch_result(nz_br), .out_load_step1(nz_ld));

    mult_booth4_unit #(.WIDTH(8), .ROB_W(4), .EARLY_ZERO(0)) dut8 (
        .clk(clk), .reset(reset), .valid_in(s8_valid), .A(s8_a), .B(s8_b), .ALUop(s8_op),
        .rs_rob_entry(s8_tag), .flush(flush), .yumi_in(s8_yumi), .ready(s8_ready),
        .valid_out(s8_valid_out), .out_rob(s8_rob), .out_result(s8_result),
        .out_branch_result(s8_br), .out_load_step1(s8_ld));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain full-width multiply of the mode-extended operands.
    function automatic logic [31:0] ref32(input logic [31:0] x, input logic [31:0] y,
                                          input logic [1:0] op);
        logic signed [65:0]  ex, ey;
        logic signed [131:0] p;
        ex = (op == 2'b11) ? $signed({2'b00, x}) : $signed({{2{x[31]}}, x});
        ey = op[1] ? $signed({2'b00, y}) : $signed({{2{y[31]}}, y});
        p  = ex * ey;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [7:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                        input logic [1:0] op);
        logic signed [9:0]  ex, ey;
        logic signed [19:0] p;
        ex = (op == 2'b11) ? $signed({2'b00, x}) : $signed({{2{x[7]}}, x});
        ey = op[1] ? $signed({2'b00, y}) : $signed({{2{y[7]}}, y});
        p  = ex * ey;
        return (op == 2'b00) ? p[7:0] : p[15:8];
    endfunction

    // Issue one op (caller guarantees ready), wait for valid_out with a bound.
    // cyc = cycle offset from the accept cycle T at which valid_out is seen.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] iop,
                          input logic [3:0] itag, input bit do_yumi,
                          output logic [31:0] res, output logic [3:0] rob, output int cyc);
        a = ia; b = ib; aluop = iop; tag = itag; valid_in = 1'b1;
        tick();
        valid_in = 1'b0; a = 32'hA5A5_5A5A; b = 32'h3C3C_C3C3; tag = ~itag;
        cyc = 1;
        while (!valid_out && cyc < 100) begin
            tick();
            cyc++;
        end
        res = out_result;
        rob = out_rob;
        if (do_yumi) begin
            yumi = 1'b1;
            tick();
            yumi = 1'b0;
        end
    endtask

    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] iop,
                        output logic [7:0] res, output int cyc);
        s8_a = ia; s8_b = ib; s8_op = iop; s8_tag = 4'h8; s8_valid = 1'b1;
        tick();
        s8_valid = 1'b0;
        cyc = 1;
        while (!s8_valid_out && cyc < 100) begin
            tick();
            cyc++;
        end
        res = s8_result;
        s8_yumi = 1'b1;
        tick();
        s8_yumi = 1'b0;
    endtask

    initial begin
        logic [31:0] res, ra, rb;
        logic [3:0]  rob;
        logic [1:0]  rop;
        logic [7:0]  r8, a8, b8;
        int          cyc;
        bit          seen;

        vecs[0]  = '{32'h0000_0007, 32'hFFFF_FFFD, 2'b00, 4'h5, 32'hFFFF_FFEB, 18};
        vecs[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 4'h1, 32'hFFFF_FFFE, 18};
        vecs[2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 4'h2, 32'h0000_0000, 18};
        vecs[3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 4'h3, 32'hFFFF_FFFF, 18};
        vecs[4]  = '{32'h8000_0000, 32'h8000_0000, 2'b01, 4'h4, 32'h4000_0000, 18};
        vecs[5]  = '{32'h0000_0000, 32'h0000_1234, 2'b11, 4'h6, 32'h0000_0000, 1};
        vecs[6]  = '{32'hDEAD_BEEF, 32'h0000_0000, 2'b00, 4'h7, 32'h0000_0000, 1};
        vecs[7]  = '{32'h0001_0000, 32'h0001_0000, 2'b00, 4'h8, 32'h0000_0000, 18};
        vecs[8]  = '{32'h0001_0000, 32'h0001_0000, 2'b11, 4'h9, 32'h0000_0001, 18};
        vecs[9]  = '{32'h8000_0000, 32'h7FFF_FFFF, 2'b01, 4'hA, 32'hC000_0000, 18};
        vecs[10] = '{32'h8000_0000, 32'h7FFF_FFFF, 2'b00, 4'hB, 32'h8000_0000, 18};
        vecs[11] = '{32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 4'hC, 32'h8000_0000, 18};
        vecs[12] = '{32'hFFFF_FFFF, 32'h0000_0002, 2'b11, 4'hD, 32'h0000_0001, 18};
        vecs[13] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 4'hE, 32'h0000_0001, 18};
        vecs[14] = '{32'hFFFF_FFFF, 32'h0000_0002, 2'b01, 4'hF, 32'hFFFF_FFFF, 18};
        vecs[15] = '{32'h0000_0002, 32'hFFFF_FFFF, 2'b10, 4'h0, 32'h0000_0001, 18};

        reset = 1'b1; flush = 1'b0;
        valid_in = 1'b0; yumi = 1'b0; a = '0; b = '0; aluop = '0; tag = '0;
        nz_valid = 1'b0; nz_yumi = 1'b0; nz_a = '0; nz_b = '0; nz_op = '0; nz_tag = '0;
        s8_valid = 1'b0; s8_yumi = 1'b0; s8_a = '0; s8_b = '0; s8_op = '0; s8_tag = '0;
        repeat (3) tick();
        reset = 1'b0;

        check("reset ready", ready, 1);
        check("reset valid_out", valid_out, 0);
        check("reset out_rob", out_rob, 0);
        check("reset out_result", out_result, 0);
        check("tied out_branch_result", out_br, 0);
        check("tied out_load_step1", out_ld, 0);

        for (int i = 0; i < c_NV; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag, 1'b1, res, rob, cyc);
            check($sformatf("vec%0d result", i), res, vecs[i].exp);
            check($sformatf("vec%0d out_rob", i), rob, vecs[i].tag);
            check($sformatf("vec%0d latency", i), cyc, vecs[i].cyc);
            check($sformatf("vec%0d ready after yumi", i), ready, 1);
        end

        // Backpressure: hold the result for 5 cycles, then yumi and reissue at once.
        run_op(32'd3, 32'd5, 2'b00, 4'h3, 1'b0, res, rob, cyc);
        check("bp first result", res, 32'd15);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp hold%0d valid_out", i), valid_out, 1);
            check($sformatf("bp hold%0d out_result", i), out_result, 32'd15);
            check($sformatf("bp hold%0d out_rob", i), out_rob, 4'h3);
        end
        yumi = 1'b1;
        check("bp ready during yumi", ready, 0);
        tick();
        yumi = 1'b0;
        check("bp ready after yumi", ready, 1);
        check("bp valid_out after yumi", valid_out, 0);
        run_op(32'd100, 32'hFFFF_FFFE, 2'b00, 4'h4, 1'b1, res, rob, cyc);
        check("bp reissue result", res, 32'hFFFF_FF38);
        check("bp reissue latency", cyc, 18);

        // Flush at T+5 with a competing valid_in.
        a = 32'h0000_1000; b = 32'h0000_0100; aluop = 2'b00; tag = 4'h7; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        repeat (4) tick();
        check("flush busy ready", ready, 0);
        flush = 1'b1; valid_in = 1'b1; a = 32'd5; b = 32'd6; tag = 4'h2;
        tick();
        flush = 1'b0; valid_in = 1'b0;
        check("flush ready at F+1", ready, 1);
        check("flush valid_out at F+1", valid_out, 0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (valid_out || !ready) seen = 1'b1;
        end
        check("flush no activity afterwards", seen, 0);
        run_op(32'h0000_1000, 32'h0000_0100, 2'b00, 4'h7, 1'b1, res, rob, cyc);
        check("post-flush result", res, 32'h0010_0000);
        check("post-flush latency", cyc, 18);

        // Reset mid-iteration at T+9.
        a = 32'h11; b = 32'h11; aluop = 2'b00; tag = 4'hA; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        repeat (8) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst busy ready", ready, 1);
        check("rst busy valid_out", valid_out, 0);
        check("rst busy out_rob", out_rob, 0);
        check("rst busy out_result", out_result, 0);

        // Reset while a result waits in S_DONE.
        run_op(32'd3, 32'd5, 2'b00, 4'hC, 1'b0, res, rob, cyc);
        check("rst done pre valid_out", valid_out, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst done ready", ready, 1);
        check("rst done valid_out", valid_out, 0);
        check("rst done out_rob", out_rob, 0);
        check("rst done out_result", out_result, 0);

        // EARLY_ZERO=0: zero operand still iterates the full count.
        nz_a = 32'd0; nz_b = 32'h0000_1234; nz_op = 2'b11; nz_tag = 4'h6; nz_valid = 1'b1;
        tick();
        nz_valid = 1'b0;
        cyc = 1;
        while (!nz_valid_out && cyc < 100) begin
            tick();
            cyc++;
        end
        check("nz latency", cyc, 18);
        check("nz result", nz_result, 0);
        check("nz out_rob", nz_rob, 4'h6);
        nz_yumi = 1'b1;
        tick();
        nz_yumi = 1'b0;

        // Reference sweep at WIDTH=32 (corner operands mixed in).
        for (int i = 0; i < 200; i++) begin
            ra  = (i % 7 == 0) ? 32'h8000_0000 : ((i % 11 == 0) ? 32'd0 : $urandom);
            rb  = (i % 5 == 0) ? 32'hFFFF_FFFF : ((i % 13 == 0) ? 32'd0 : $urandom);
            rop = 2'($urandom_range(0, 3));
            run_op(ra, rb, rop, 4'(i), 1'b1, res, rob, cyc);
            check($sformatf("rand32 %0d a=%0h b=%0h op=%0d", i, ra, rb, rop), res, ref32(ra, rb, rop));
            check($sformatf("rand32 %0d latency", i), cyc, ((ra == 0) || (rb == 0)) ? 1 : 18);
        end

        // Reference sweep at WIDTH=8.
        for (int i = 0; i < 300; i++) begin
            a8  = (i % 9 == 0) ? 8'h80 : 8'($urandom);
            b8  = (i % 6 == 0) ? 8'hFF : 8'($urandom);
            rop = 2'(i % 4);
            run8(a8, b8, rop, r8, cyc);
            check($sformatf("rand8 %0d a=%0h b=%0h op=%0d", i, a8, b8, rop), r8, ref8(a8, b8, rop));
            check($sformatf("rand8 %0d latency", i), cyc, 6);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_booth4_unit.md
# mult_booth4_unit

Parametrised radix-4 Booth integer multiply functional unit for the execute stage. Accepts one issued multiply from its reservation station, iterates two multiplier bits per cycle, and presents a tagged result to the CDB arbiter under a valid/yumi handshake. It supports all four RV32M multiply modes (MUL, MULH, MULHSU, MULHU), an early-out for zero operands, and a flush that aborts an in-flight operation.

## Interface
Parameters:
- WIDTH, 32: operand and result width. Even, at least 8.
- ROB_W, 4: ROB tag width.
- EARLY_ZERO, 1: when 1, a zero operand completes without iterating.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- valid_in  in  1  operation is presented; accepted only when ready=1.
- A  in  WIDTH  rs1 operand, used as the multiplicand.
- B  in  WIDTH  rs2 operand, used as the multiplier.
- ALUop  in  2  mode: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- rs_rob_entry  in  ROB_W  destination ROB tag.
- flush  in  1  aborts any in-flight or completed-but-unconsumed operation.
- yumi_in  in  1  CDB consumes the result this cycle; meaningful only while valid_out=1.
- ready  out  1  unit is idle and can accept an operation.
- valid_out  out  1  out_result and out_rob are valid and held stable.
- out_rob  out  ROB_W  tag of the completed operation.
- out_result  out  WIDTH  selected half of the product.
- out_branch_result, out_load_step1  out  1 each  tied to 0; used for CDB_packet_t packing.

## Operation
- FSM states:
  - S_IDLE: ready=1.
  - S_BUSY: iterating.
  - S_DONE: valid_out=1.
- Accept: an operation is accepted when valid_in & ready. On accept, the unit latches the tag, the mode and both extended operands.
- Operand extension to WIDTH+2 bits:
  - A is sign-extended for modes 00, 01 and 10, and zero-extended for mode 11.
  - B is sign-extended for modes 00 and 01, and zero-extended for modes 10 and 11.
- Iteration:
  - ITER = WIDTH/2 + 1 (17 at WIDTH=32).
  - Each S_BUSY cycle examines the Booth triplet {B[i+1], B[i], B[i-1]}, with an implicit 0 below bit 0.
  - It adds 0, ±A or ±2A to a signed upper accumulator, then arithmetic-shifts the {acc, multiplier} register right by 2.
  - Accumulator width is WIDTH+4. Internal arithmetic must not overflow for any input or mode.
- Counter: loaded with ITER on accept and decremented once per S_BUSY cycle. The FSM transitions S_BUSY to S_DONE when the counter equals 1.
- Result selection: mode 00 returns product[WIDTH-1:0]; all other modes return product[2*WIDTH-1:WIDTH].
- Early-out: when EARLY_ZERO=1 and A==0 or B==0 at accept, the FSM goes S_IDLE to S_DONE directly with result 0.
- S_DONE to S_IDLE on yumi_in.
  - yumi_in in S_IDLE or S_BUSY is ignored.
  - A new operation cannot be accepted in the same cycle as yumi_in; ready rises the following cycle.
- Flush: if flush=1 in any state, the FSM goes to S_IDLE next cycle. Flush has priority over valid_in, yumi_in and iteration, and no result is ever emitted for the flushed operation.
- Reset: has priority over everything, including mid-iteration and S_DONE.
  - After reset: state S_IDLE, ready=1, valid_out=0, out_rob=0, out_result=0.
  - All outputs are registered or state-decoded; there are no combinational paths from inputs to outputs.

## Timing
- Accept at edge T (valid_in & ready sampled high). ready=0 from T+1.
- Normal latency: valid_out=1 from cycle T+ITER+1 (T+18 at WIDTH=32) and held until the yumi_in cycle.
- Early-out latency: valid_out=1 at T+1.
- Throughput:
  - One operation per ITER+2 cycles with immediate yumi_in.
  - Back-to-back spacing: yumi at cycle D, ready at D+1, next accept at D+1.
- While valid_out=1, out_result and out_rob must not change until yumi_in or flush.
- Flush at cycle F: ready=1 and valid_out=0 at F+1.

## Test plan
- MUL, A=7, B=0xFFFFFFFD, tag 5 -> valid_out at T+18, out_result=0xFFFFFFEB, out_rob=5.
- A=B=0xFFFFFFFF, one run per high mode -> MULHU=0xFFFFFFFE, MULH=0x00000000, MULHSU=0xFFFFFFFF. Also MULH with A=B=0x80000000 -> 0x40000000.
- Backpressure: complete an operation, hold yumi_in low for 5 cycles -> valid_out and out_result stable throughout. Assert yumi -> ready=1 the next cycle, and a new op is accepted that cycle.
- Flush at T+5 during S_BUSY, with valid_in also high -> idle at T+6, the new op is not accepted, and valid_out never rises for the flushed op. A fresh op then completes correctly.
- EARLY_ZERO=1, A=0, B=0x1234, MULHU -> valid_out at T+1, out_result=0. With EARLY_ZERO=0, the same input completes at T+18 with result 0.
- Reset asserted at T+9 mid-iteration and also in S_DONE -> next cycle ready=1, valid_out=0, out_rob=0, out_result=0.
- Randomised check: 10k random (A, B, mode) triples at WIDTH=32, 8 and 16 -> every result matches a 2*WIDTH-bit reference product.
